// File: rtl/noc_ring_router.sv
// ============================================================================
//  Module   : noc_ring_router
//  Purpose  : Bidirectional-ring NoC router node with East, West and Local
//             ports. Each input has its own FIFO. Each output has its own
//             round-robin arbiter. Multicast flits are split per output
//             direction, and a partially granted head keeps only the
//             destinations that are still undelivered, so no node receives
//             a flit twice.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Port index in every packed vector: 0 = East, 1 = West, 2 = Local.
//  Flit format: bit 0 valid, bits [NODES:1] destination mask
//               (bit n+1 = node n), upper bits payload.
//
//  Ports
//    clk         in   clock
//    rst_n       in   asynchronous active-low reset
//    write_i     in   [3]          per-input flit write strobe
//    data_i      in   [3*WIDTH]    per-input flit
//    full_o      out  [3]          per-input stop to upstream (registered)
//    overflow_o  out  [3]          sticky: write arrived while FIFO was full
//    full_i      in   [3]          per-output stop from downstream
//    write_o     out  [3]          per-output flit strobe (registered)
//    data_o      out  [3*WIDTH]    per-output flit (registered)
//    flit_cnt_o  out  [3*16]       saturating write_o pulse counters
//                                  (only with NOC_RING_STATS_EN defined)
//
//  Build option: NOC_RING_STATS_EN adds the per-output flit counters.
// ============================================================================
`default_nettype none

module noc_ring_router #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 8,
    parameter int NODES   = 4,
    parameter int NODE_ID = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2:0]           write_i,
    input  logic [3*WIDTH-1:0]   data_i,
    output logic [2:0]           full_o,
    output logic [2:0]           overflow_o,
    input  logic [2:0]           full_i,
    output logic [2:0]           write_o,
    output logic [3*WIDTH-1:0]   data_o
`ifdef NOC_RING_STATS_EN
    ,
    output logic [3*16-1:0]      flit_cnt_o
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_DEPTH_CNT = (AW+1)'(DEPTH);
    // Two entries of slack cover the registered full_o -> upstream round trip.
    localparam logic [AW:0] c_FULL_CNT  = (AW+1)'(DEPTH - 2);

    // Per-output set of destination nodes reached through that output.
    // Clockwise distance 0 is local, 1..NODES/2 goes East (tie goes East),
    // anything farther goes West.
    function automatic logic [2:0][NODES-1:0] f_dirmask();
        logic [2:0][NODES-1:0] m;
        int                    d;
        m = '0;
        for (int n = 0; n < NODES; n++) begin
            d = (n - NODE_ID + NODES) % NODES;
            if (d == 0)
                m[2][n] = 1'b1;
            else if (d <= NODES / 2)
                m[0][n] = 1'b1;
            else
                m[1][n] = 1'b1;
        end
        return m;
    endfunction

    localparam logic [2:0][NODES-1:0] c_DIRMASK = f_dirmask();

    function automatic logic [1:0] f_inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]        r_mem [3][DEPTH];
    logic [2:0][AW-1:0]      r_wptr;
    logic [2:0][AW-1:0]      r_rptr;
    logic [2:0][AW:0]        r_cnt;
    logic [2:0]              r_full;
    logic [2:0]              r_ovf;
    logic [2:0][1:0]         r_rrptr;   // round-robin pointer per output
    logic [2:0]              r_write;
    logic [2:0][WIDTH-1:0]   r_data;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [2:0][WIDTH-1:0]   w_head;
    logic [2:0]              w_live;
    logic [2:0][NODES-1:0]   w_hmask;
    logic [2:0][2:0]         w_req;     // [input][output]
    logic [2:0][2:0]         w_gnt;     // [output][input]
    logic [2:0]              w_gany;
    logic [2:0][1:0]         w_gsel;
    logic [1:0]              w_idx;
    logic [2:0][WIDTH-1:0]   w_fork;
    logic [2:0][NODES-1:0]   w_clr;
    logic [2:0][NODES-1:0]   w_resid;
    logic [2:0]              w_pop;
    logic [2:0]              w_push;
    logic [2:0][AW:0]        w_cnt_nxt;

    // Head inspection and per-output requests.
    always_comb begin
        w_head  = '0;
        w_live  = '0;
        w_hmask = '0;
        w_req   = '0;
        for (int i = 0; i < 3; i++) begin
            w_head[i]  = r_mem[i][r_rptr[i]];
            w_live[i]  = (r_cnt[i] != '0);
            w_hmask[i] = w_head[i][NODES:1];
            for (int o = 0; o < 3; o++)
                w_req[i][o] = w_live[i] & w_head[i][0] &
                              (|(w_hmask[i] & c_DIRMASK[o]));
        end
    end

    // Round-robin arbitration per output: search pointer, +1, +2.
    always_comb begin
        w_gnt  = '0;
        w_gany = '0;
        w_gsel = '0;
        w_idx  = '0;
        for (int o = 0; o < 3; o++) begin
            w_idx = r_rrptr[o];
            for (int k = 0; k < 3; k++) begin
                if (!full_i[o] && !w_gany[o] && w_req[w_idx][o]) begin
                    w_gnt[o][w_idx] = 1'b1;
                    w_gany[o]       = 1'b1;
                    w_gsel[o]       = w_idx;
                end
                w_idx = f_inc3(w_idx);
            end
        end
    end

    // Fork: each output carries only the destinations routed through it.
    // Any destinations granted this cycle are removed from the head's mask.
    always_comb begin
        w_fork    = '0;
        w_clr     = '0;
        w_resid   = '0;
        w_pop     = '0;
        w_push    = '0;
        w_cnt_nxt = '0;
        for (int o = 0; o < 3; o++) begin
            w_fork[o]          = w_head[w_gsel[o]];
            w_fork[o][NODES:1] = w_hmask[w_gsel[o]] & c_DIRMASK[o];
        end
        for (int i = 0; i < 3; i++) begin
            for (int o = 0; o < 3; o++)
                if (w_gnt[o][i])
                    w_clr[i] = w_clr[i] | c_DIRMASK[o];
            w_resid[i] = w_hmask[i] & ~w_clr[i];
            // Invalid or empty-mask heads fall out here too (residual is 0
            // or valid is 0), which discards them without any output.
            w_pop[i]   = w_live[i] & (~w_head[i][0] | (w_resid[i] == '0));
            w_push[i]  = write_i[i] & (r_cnt[i] != c_DEPTH_CNT);
            case ({w_push[i], w_pop[i]})
                2'b10:   w_cnt_nxt[i] = r_cnt[i] + (AW+1)'(1);
                2'b01:   w_cnt_nxt[i] = r_cnt[i] - (AW+1)'(1);
                default: w_cnt_nxt[i] = r_cnt[i];
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++)
                for (int e = 0; e < DEPTH; e++)
                    r_mem[i][e] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_cnt   <= '0;
            r_full  <= '0;
            r_ovf   <= '0;
            r_rrptr <= '0;
            r_write <= '0;
            r_data  <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                // A residual write targets the head slot. A push targets the
                // tail slot. The two slots are never the same while both
                // can happen, because the FIFO is then neither empty nor full.
                if (w_pop[i])
                    r_rptr[i] <= r_rptr[i] + AW'(1);
                else if (w_live[i])
                    r_mem[i][r_rptr[i]][NODES:1] <= w_resid[i];
                if (w_push[i]) begin
                    r_mem[i][r_wptr[i]] <= data_i[i*WIDTH +: WIDTH];
                    r_wptr[i]           <= r_wptr[i] + AW'(1);
                end
                if (write_i[i] && !w_push[i])
                    r_ovf[i] <= 1'b1;
                r_cnt[i]  <= w_cnt_nxt[i];
                r_full[i] <= (w_cnt_nxt[i] >= c_FULL_CNT);
            end
            for (int o = 0; o < 3; o++) begin
                r_write[o] <= w_gany[o];
                if (w_gany[o]) begin
                    r_data[o]  <= w_fork[o];
                    r_rrptr[o] <= f_inc3(w_gsel[o]);
                end
            end
        end
    end

    assign full_o     = r_full;
    assign overflow_o = r_ovf;
    assign write_o    = r_write;
    assign data_o     = r_data;

`ifdef NOC_RING_STATS_EN
    logic [2:0][15:0] r_flit_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flit_cnt <= '0;
        end else begin
            for (int o = 0; o < 3; o++)
                if (w_gany[o] && (r_flit_cnt[o] != 16'hFFFF))
                    r_flit_cnt[o] <= r_flit_cnt[o] + 16'd1;
        end
    end

    assign flit_cnt_o = r_flit_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_noc_ring_router.sv
// ============================================================================
//  Module   : tb_noc_ring_router
//  Purpose  : Self-checking bench for noc_ring_router (NODES=4, NODE_ID=1,
//             DEPTH=4, WIDTH=16). It keeps one expected-flit queue per
//             output and pops from it on every write_o pulse.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_noc_ring_router;

    localparam int W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [2:0]       write_i;
    logic [3*W-1:0]   data_i;
    logic [2:0]       full_o;
    logic [2:0]       overflow_o;
    logic [2:0]       full_i;
    logic [2:0]       write_o;
    logic [3*W-1:0]   data_o;
`ifdef NOC_RING_STATS_EN
    logic [3*16-1:0]  flit_cnt_o;
`endif

    noc_ring_router #(.WIDTH(W), .DEPTH(4), .NODES(4), .NODE_ID(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .write_i    (write_i),
        .data_i     (data_i),
        .full_o     (full_o),
        .overflow_o (overflow_o),
        .full_i     (full_i),
        .write_o    (write_o),
        .data_o     (data_o)
`ifdef NOC_RING_STATS_EN
        ,
        .flit_cnt_o (flit_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int  n_chk  = 0;
    int  n_fail = 0;
    bit  mon_en = 1'b0;

    logic [15:0] q_e[$];
    logic [15:0] q_w[$];
    logic [15:0] q_l[$];
    logic [15:0] got;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] mk(input logic [10:0] pl, input logic [3:0] m);
        return {pl, m, 1'b1};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int p, input logic [15:0] f);
        data_i[p*W +: W] = f;
        write_i[p]       = 1'b1;
    endtask

    task automatic wait_drain();
        int i;
        i = 0;
        while ((q_e.size() + q_w.size() + q_l.size()) != 0 && i < 200) begin
            @(posedge clk);
            i++;
        end
        #1;
        check("drain", 32'(q_e.size() + q_w.size() + q_l.size()), 32'd0);
        repeat (3) step();
    endtask

    // Scoreboard monitor: sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (write_o[0]) begin
                got = data_o[15:0];
                if (q_e.size() != 0) check("sb_E", 32'(got), 32'(q_e.pop_front()));
                else                 check("sb_E_extra", 32'(write_o[0]), 32'd0);
            end
            if (write_o[1]) begin
                got = data_o[31:16];
                if (q_w.size() != 0) check("sb_W", 32'(got), 32'(q_w.pop_front()));
                else                 check("sb_W_extra", 32'(write_o[1]), 32'd0);
            end
            if (write_o[2]) begin
                got = data_o[47:32];
                if (q_l.size() != 0) check("sb_L", 32'(got), 32'(q_l.pop_front()));
                else                 check("sb_L_extra", 32'(write_o[2]), 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        write_i = '0;
        data_i  = '0;
        full_i  = '0;
        step();
        step();
        check("rst_write_o", 32'(write_o), 32'd0);
        check("rst_data_o", data_o[31:0], 32'd0);
        check("rst_data_o_hi", 32'(data_o[47:32]), 32'd0);
        check("rst_full_o", 32'(full_o), 32'd0);
        check("rst_overflow_o", 32'(overflow_o), 32'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        step();

        // Unicast tie: node 3 is distance 2 from node 1, so it goes East.
        put(2, mk(11'h011, 4'b1000));
        q_e.push_back(mk(11'h011, 4'b1000));
        step();
        write_i = '0;
        check("t1_lat_edge_k", 32'(write_o), 32'd0);
        step();
        check("t1_lat_edge_k1", 32'(write_o), 32'b001);
        wait_drain();

        // Triple fork from West to nodes 0, 1 and 2.
        put(1, mk(11'h022, 4'b0111));
        q_l.push_back(mk(11'h022, 4'b0010));
        q_e.push_back(mk(11'h022, 4'b0100));
        q_w.push_back(mk(11'h022, 4'b0001));
        step();
        write_i = '0;
        step();
        check("t2_fork_same_cycle", 32'(write_o), 32'b111);
        wait_drain();

        // Partial grant: East is blocked, so only Local is delivered first.
        full_i[0] = 1'b1;
        put(2, mk(11'h033, 4'b0110));
        q_l.push_back(mk(11'h033, 4'b0010));
        step();
        write_i = '0;
        repeat (4) step();
        check("t3_E_held", 32'(write_o), 32'd0);
        check("t3_q_L_done", 32'(q_l.size()), 32'd0);
        q_e.push_back(mk(11'h033, 4'b0100));
        full_i[0] = 1'b0;
        step();
        check("t3_E_grant", 32'(write_o), 32'b001);
        wait_drain();

        // Round-robin: the Local output pointer is at East here, so the
        // grants go E, W, L, E, ...
        for (int s = 0; s < 3; s++) begin
            for (int p = 0; p < 3; p++) begin
                put(p, mk(11'(p * 16 + s), 4'b0010));
                q_l.push_back(mk(11'(p * 16 + s), 4'b0010));
            end
            step();
        end
        write_i = '0;
        wait_drain();

        // Full and overflow on the East input with East output blocked.
        full_i[0] = 1'b1;
        for (int s = 0; s < 5; s++) begin
            put(0, mk(11'(8'h50 + s), 4'b0100));
            if (s < 4) q_e.push_back(mk(11'(8'h50 + s), 4'b0100));
            step();
            check($sformatf("t5_full_o_w%0d", s + 1), 32'(full_o[0]), (s >= 1) ? 32'd1 : 32'd0);
            check($sformatf("t5_ovf_w%0d", s + 1), 32'(overflow_o[0]), (s == 4) ? 32'd1 : 32'd0);
        end
        write_i   = '0;
        full_i[0] = 1'b0;
        wait_drain();
        check("t5_full_o_cleared", 32'(full_o[0]), 32'd0);
        check("t5_ovf_sticky", 32'(overflow_o[0]), 32'd1);

        // Reset mid-stream while queues hold flits and write_o is active.
        mon_en    = 1'b0;
        full_i[0] = 1'b1;
        for (int s = 0; s < 3; s++) begin
            put(0, mk(11'(8'h60 + s), 4'b0100));
            put(1, mk(11'(8'h70 + s), 4'b0010));
            step();
        end
        check("t6_L_active", 32'(write_o[2]), 32'd1);
        check("t6_full_E", 32'(full_o[0]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_write_o", 32'(write_o), 32'd0);
        check("t6_rst_data_lo", data_o[31:0], 32'd0);
        check("t6_rst_data_hi", 32'(data_o[47:32]), 32'd0);
        check("t6_rst_full_o", 32'(full_o), 32'd0);
        check("t6_rst_ovf", 32'(overflow_o), 32'd0);
        write_i = '0;
        full_i  = '0;
        step();
        step();
        rst_n = 1'b1;
        q_e.delete();
        q_w.delete();
        q_l.delete();
        mon_en = 1'b1;
        put(2, mk(11'h07F, 4'b1000));
        q_e.push_back(mk(11'h07F, 4'b1000));
        step();
        write_i = '0;
        check("t6_lat_edge_k", 32'(write_o), 32'd0);
        step();
        check("t6_lat_edge_k1", 32'(write_o), 32'b001);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
